// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: key indices, the key bus
// width and helpers that size the phase and toggle counters.
// Optional build macro: LED_PATTERN_PAUSE_EN adds the pause key (KEY[3]).
package led_pkg;

    localparam int KEY_SLOW    = 0;
    localparam int KEY_FAST    = 1;
    localparam int KEY_DEFAULT = 2;
    localparam int KEY_PAUSE   = 3;

`ifdef LED_PATTERN_PAUSE_EN
    localparam int KEY_W = 4;
`else
    localparam int KEY_W = 3;
`endif

    // 0.25 s at 50 MHz
    localparam int TICK_STEP_DEFAULT = 12500000;

    // Phase runs 0..num_ch (num_ch itself is the all-banks phase).
    function automatic int phase_w(input int num_ch);
        return (num_ch < 1) ? 1 : $clog2(num_ch + 1);
    endfunction

    // Toggle runs 0..2*flashes-1.
    function automatic int toggle_w(input int flashes);
        return (flashes < 1) ? 1 : $clog2(2 * flashes);
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Board-side bundle of the sequencer: push-buttons in, LEDs and step count out.
// Ports: KEY (active-low buttons, 3 bits or 4 with LED_PATTERN_PAUSE_EN),
//        LED (NUM_CH*WIDTH), STEP (4-bit period in steps).
// No handshake: all signals are free-running levels.
interface led_pattern_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 8
);
    logic [led_pkg::KEY_W-1:0] KEY;
    logic [NUM_CH*WIDTH-1:0]   LED;
    logic [3:0]                STEP;

    // master: board / testbench side that drives the buttons
    modport master (output KEY, input LED, input STEP);
    // slave: the sequencer
    modport slave  (input KEY, output LED, output STEP);
endinterface

// File: rtl/key_release_detect.sv
// Purpose: two-flop synchroniser for one active-low button plus a release-edge pulse.
// Latency: pulse is high in the cycle after the 2nd edge that sees the key high.
// Backpressure: none; a pulse that nobody consumes is simply lost.
// Ports: clk, rst (sync active-high), key_n (raw button), level (synchronised
//        button level), rel_pulse (one-cycle release pulse).
module key_release_detect (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic rel_pulse
);
    logic meta;
    logic sync;
    logic prev;

    // Flops reset to 1 (button released) so leaving reset never looks like a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= key_n;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level     = sync;
    assign rel_pulse = sync & ~prev;
endmodule

// File: rtl/led_pattern_sequencer.sv
// Purpose: flashes NUM_CH LED banks one at a time then all together, FLASHES times per phase.
// Latency: LED/STEP registered; first flash steps*TICK_STEP edges after reset, key acts 3 edges after release.
// Backpressure: none; outputs are free-running, losing key pulses are dropped.
// Ports: CLOCK_50, RESET (sync active-high), io (slave modport: KEY in, LED/STEP out).
// Optional build macro: LED_PATTERN_PAUSE_EN enables KEY[3] pause toggle.
module led_pattern_sequencer import led_pkg::*; #(
    parameter int NUM_CH        = 2,
    parameter int WIDTH         = 8,
    parameter int TICK_STEP     = TICK_STEP_DEFAULT,
    parameter int MIN_STEPS     = 1,
    parameter int MAX_STEPS     = 8,
    parameter int DEFAULT_STEPS = 2,
    parameter int FLASHES       = 3
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    led_pattern_sequencer_if.slave  io
);
    localparam int P_W = phase_w(NUM_CH);
    localparam int T_W = toggle_w(FLASHES);
    localparam int LW  = NUM_CH * WIDTH;

    localparam logic [P_W-1:0] P_ALL  = P_W'(NUM_CH);
    localparam logic [T_W-1:0] T_LAST = T_W'(2 * FLASHES - 1);
    localparam logic [3:0]     S_MIN  = 4'(MIN_STEPS);
    localparam logic [3:0]     S_MAX  = 4'(MAX_STEPS);
    localparam logic [3:0]     S_DEF  = 4'(DEFAULT_STEPS);

    // ---------------------------------------------------------------- keys
    logic [KEY_W-1:0] key_lvl;
    logic [KEY_W-1:0] key_rel;

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        key_release_detect u_key (
            .clk       (CLOCK_50),
            .rst       (RESET),
            .key_n     (io.KEY[i]),
            .level     (key_lvl[i]),
            .rel_pulse (key_rel[i])
        );
    end

    // Only the restore key is used as a level; the others only as pulses.
    logic unused_key;
    assign unused_key = ^{key_lvl, key_rel};

    logic restore;
    assign restore = ~key_lvl[KEY_DEFAULT];

    // ---------------------------------------------------------------- state
    logic [31:0]    tick_cnt, tick_nx;
    logic [3:0]     steps,    steps_nx;
    logic [P_W-1:0] phase,    phase_nx;
    logic [T_W-1:0] tog,      tog_nx;
    logic [LW-1:0]  led,      led_nx;
    logic           run;

`ifdef LED_PATTERN_PAUSE_EN
    logic paused;

    always_ff @(posedge CLOCK_50) begin
        if (RESET)
            paused <= 1'b0;
        else if (key_rel[KEY_PAUSE])
            paused <= ~paused;
    end

    assign run = ~paused;
`else
    assign run = 1'b1;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            tick_cnt <= '0;
            steps    <= S_DEF;
            phase    <= '0;
            tog      <= '0;
            led      <= '0;
        end else begin
            tick_cnt <= tick_nx;
            steps    <= steps_nx;
            phase    <= phase_nx;
            tog      <= tog_nx;
            led      <= led_nx;
        end
    end

    // ---------------------------------------------------------------- next state
    logic [31:0] period_last;
    logic        flash;
    logic        period_chg;

    assign period_last = 32'(steps) * 32'(TICK_STEP) - 32'd1;

    always_comb begin
        tick_nx    = tick_cnt;
        steps_nx   = steps;
        phase_nx   = phase;
        tog_nx     = tog;
        led_nx     = led;
        flash      = 1'b0;
        period_chg = 1'b0;

        if (restore) begin
            // Restore held: timer parked at zero, pattern frozen, keys ignored.
            steps_nx = S_DEF;
            tick_nx  = '0;
        end else begin
            // Slow beats fast; a slow pulse at MAX still swallows a coincident fast.
            if (key_rel[KEY_SLOW]) begin
                if (steps < S_MAX) begin
                    steps_nx   = steps + 4'd1;
                    period_chg = 1'b1;
                end
            end else if (key_rel[KEY_FAST]) begin
                if (steps > S_MIN) begin
                    steps_nx   = steps - 4'd1;
                    period_chg = 1'b1;
                end
            end

            flash = run && (tick_cnt == period_last);

            if (flash || period_chg)
                tick_nx = '0;
            else if (run)
                tick_nx = tick_cnt + 32'd1;

            if (flash) begin
                led_nx = '0;
                if (!tog[0]) begin
                    for (int b = 0; b < NUM_CH; b++) begin
                        if (phase == P_ALL || phase == P_W'(b))
                            led_nx[b*WIDTH +: WIDTH] = '1;
                    end
                end

                if (tog == T_LAST) begin
                    tog_nx   = '0;
                    phase_nx = (phase == P_ALL) ? '0 : phase + P_W'(1);
                end else begin
                    tog_nx = tog + T_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign io.LED  = led;
    assign io.STEP = steps;

endmodule
